// File: rtl/cpu_types_pkg.sv
// Shared pipeline types; this slice adds the fetch-stage state and queue entry.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory side, decode side and redirect/halt controls.
interface fetch_unit_if #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic [WORD_W-1:0] imemload;
  logic              ihit;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              halt;
  logic              inst_valid;
  logic [WORD_W-1:0] inst;
  logic [WORD_W-1:0] inst_pc;
  logic [WORD_W-1:0] inst_npc;
  logic              inst_ready;
  logic              halted;
  logic [CNT_W-1:0]  count;

  modport master (
    output imemREN, imemaddr, inst_valid, inst, inst_pc, inst_npc, halted, count,
    input  imemload, ihit, redirect, redirect_pc, halt, inst_ready
  );

  modport slave (
    input  imemREN, imemaddr, inst_valid, inst, inst_pc, inst_npc, halted, count,
    output imemload, ihit, redirect, redirect_pc, halt, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two queue of fetched {instr, pc} entries with flush.
// Overflowing pushes and underflowing pops are dropped; flush wins over both.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [W-1:0]               head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable once counted in.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, queues returned words, handles redirect and sticky halt.
// Outputs depend only on registered state plus redirect/halt; reads stall while the queue is full.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter int                WORD_W  = 32,
  parameter int                DEPTH   = 2,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input logic           CLK,
  input logic           nRST,
  fetch_unit_if.master  fif
);
  localparam int ENT_W = 2 * WORD_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              ren, push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  head;
  logic [WORD_W-1:0] head_instr, head_pc;

  fetch_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({fif.imemload, pc_q}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

  assign head_instr = head[ENT_W-1:WORD_W];
  assign head_pc    = head[WORD_W-1:0];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ren     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      FETCH: begin
        ren  = !fifo_full && !fif.redirect && !fif.halt;
        push = ren && fif.ihit;
        pop  = !fifo_empty && fif.inst_ready && !fif.redirect && !fif.halt;
        // Halt outranks redirect; both discard this cycle's hit and pop.
        if (fif.halt) begin
          state_d = HALTED;
          flush   = 1'b1;
        end else if (fif.redirect) begin
          flush = 1'b1;
          pc_d  = {fif.redirect_pc[WORD_W-1:2], 2'b00};
        end else if (push) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  assign fif.imemREN    = nRST && ren;
  assign fif.imemaddr   = nRST ? pc_q : '0;
  assign fif.inst_valid = nRST && (state_q == FETCH) && !fifo_empty;
  assign fif.inst       = nRST ? head_instr : '0;
  assign fif.inst_pc    = nRST ? head_pc : '0;
  assign fif.inst_npc   = nRST ? head_pc + PC_STEP : '0;
  assign fif.halted     = nRST && (state_q == HALTED);
  assign fif.count      = nRST ? fifo_count : '0;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the MIPS pipeline, sitting between the instruction side of `datapath_cache_if` and decode. It owns the fetch PC, issues instruction-memory reads, buffers returned instructions with their PCs in a small queue, and supports redirect (branch/jump/jr) and a sticky halt. It replaces the free-running PC register in the single-cycle datapath with a stall-aware, flushable fetch stage.

## Interface
- `PC_INIT`, 0: fetch PC after reset; must be word-aligned.
- `WORD_W`, 32: instruction and address width.
- `DEPTH`, 2: instruction queue entries; power of two, ≥2.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `imemREN` out 1: instruction read request.
- `imemaddr` out WORD_W: read address; equals fetch PC.
- `imemload` in WORD_W: returned instruction; valid when `ihit`.
- `ihit` in 1: read complete this cycle.
- `redirect` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in WORD_W: new fetch PC; bits [1:0] ignored and forced to 0.
- `halt` in 1: decode saw a halt instruction; stop fetching.
- `inst_valid` out 1: queue head valid.
- `inst` out WORD_W: head instruction.
- `inst_pc` out WORD_W: head PC.
- `inst_npc` out WORD_W: head PC + 4.
- `inst_ready` in 1: decode consumes the head this cycle.
- `halted` out 1: sticky halt status.
- `count` out $clog2(DEPTH+1): queue occupancy.

## Operation
- State machine: `FETCH` and `HALTED`.
- `FETCH`: `imemREN = !full && !redirect && !halt`. `full` means `count == DEPTH`. No same-cycle pass-through.
- Push: `imemREN && ihit` writes {`imemload`, fetch PC} at the tail. Fetch PC then advances by 4, modulo 2^WORD_W, so 0xFFFFFFFC becomes 0.
- Pop: `inst_valid && inst_ready` advances the head.
- Push and pop in the same cycle leave `count` unchanged.
- Redirect in `FETCH`:
  - Queue flushes: `count` becomes 0 and pointers reset.
  - Fetch PC becomes `{redirect_pc[WORD_W-1:2],2'b00}`.
  - Any `ihit` and any pop in that cycle are discarded.
- Halt:
  - Moves the block to `HALTED` and flushes the queue.
  - `halt` takes priority over a `redirect` in the same cycle.
- `HALTED`:
  - `imemREN=0` and `inst_valid=0`.
  - `halted=1`, and it stays set until reset.
  - `redirect`, `ihit` and `inst_ready` are ignored.
- `ihit` while `imemREN=0` is ignored.
- Decode must not raise `inst_ready` while `inst_valid=0`; if it does, the block ignores it.

## Timing
- Reset applies on the clock edge with `nRST=0`. While `nRST=0`, all outputs are held low.
- Values after reset:
  - State `FETCH`.
  - Fetch PC = `PC_INIT`.
  - `count=0`, `inst_valid=0`, `halted=0`.
  - `imemaddr=PC_INIT`.
  - `imemREN=1` from the first cycle after reset is released.
- Reset mid-operation drops all queue contents and any pending read.
- Latency: a push on cycle N gives `inst_valid=1` on cycle N+1 with that entry at the head, if the queue was empty.
- `imemREN`, `imemaddr`, `inst_valid`, `inst`, `inst_pc`, `inst_npc` and `count` are combinational from registered state plus `redirect`/`halt` only. There is no path from `ihit` to `imemREN`.
- Redirect on cycle N: the first fetch from the target is requested on cycle N+1. `inst_valid=0` on N+1.
- Halt on cycle N: `halted=1` and `imemREN=0` from N+1.
- Full queue: `imemREN` drops on the cycle `count==DEPTH`. It rises the cycle after the first pop.

## Structure
- Add to `cpu_types_pkg`:
  - `fetch_state_t` enum {FETCH, HALTED}.
  - `fetch_entry_t` packed struct {`word_t instr; word_t pc;`}.
- `word_t` is used when WORD_W=32.
- One sub-module: `fetch_fifo`.
  - Parametrised by DEPTH and entry width.
  - Ports: push, pop, flush, full, empty, count, head.
  - Uses a synchronous, active-low reset.
- `fetch_unit` holds the FSM, the fetch PC and the redirect/halt priority logic.

## Test plan
- Reset with PC_INIT=0x40, `ihit` held high, `inst_ready` high:
  - `imemaddr` steps 0x40, 0x44, 0x48.
  - `inst_pc`/`inst_npc` follow one cycle later, e.g. 0x40/0x44.
- `inst_ready=0` with `ihit=1`, DEPTH=2:
  - After 2 pushes: `count=2` and `imemREN=0`.
  - Raise `inst_ready` for one cycle: `count=1`; `imemREN=1` the next cycle.
- `redirect=1`, `redirect_pc=0x103` with `ihit=1` and 2 entries queued:
  - Next cycle: `count=0`, `inst_valid=0`, `imemaddr=0x100`.
  - The discarded word never appears at `inst`.
- `halt` and `redirect` together:
  - Next cycle: `halted=1`, `imemREN=0`, `count=0`.
  - Later `ihit`/`redirect` cause no change until `nRST=0` restores `imemaddr=PC_INIT` and `halted=0`.
- Fetch PC 0xFFFFFFFC with `ihit`:
  - Next `imemaddr=0x00000000`.
  - The pushed entry has `inst_pc=0xFFFFFFFC` and `inst_npc=0x00000000`.
- `nRST` asserted mid-stream with a full queue:
  - Next cycle: `count=0`, `inst_valid=0`, `imemaddr=PC_INIT`.
  - No stale entry ever appears.
